// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit path: code space, FSM states,
// element/gap lengths in units, and the lookup record returned by morse_rom.
package morse_pkg;

   localparam logic [5:0] CODE_SPACE     = 6'd36;
   localparam logic [5:0] CODE_MAX_VALID = 6'd36;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MARK  = 3'd1,
      ST_GAP   = 3'd2,
      ST_CGAP  = 3'd3,
      ST_SPACE = 3'd4,
      ST_ERR   = 3'd5
   } morse_state_t;

   localparam int unsigned UNITS_DOT    = 1;
   localparam int unsigned UNITS_DASH   = 3;
   localparam int unsigned UNITS_EGAP   = 1;
   localparam int unsigned UNITS_CGAP   = 3;
   localparam int unsigned UNITS_WSPACE = 4;

   // pat is MSB-first, 1 = dash; only the top len bits are meaningful.
   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pat;
   } morse_lut_t;

   // Unit counter runs 0..units-1, so the terminal value is units-1.
   function automatic logic [1:0] last_unit(input int unsigned units);
      return 2'(units - 1);
   endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character code -> {valid, len, pat} lookup (ITU A-Z, 0-9).
// Codes 36..63 report valid = 0; the word space is handled by the caller.
module morse_rom
   import morse_pkg::*;
(
   input  logic [5:0]  i_code,
   output logic        o_valid,
   output morse_lut_t  o_lut
);

   always_comb begin
      o_valid = 1'b1;
      o_lut   = '0;
      case (i_code)
         6'd0:  o_lut = '{len: 3'd5, pat: 5'b11111};
         6'd1:  o_lut = '{len: 3'd5, pat: 5'b01111};
         6'd2:  o_lut = '{len: 3'd5, pat: 5'b00111};
         6'd3:  o_lut = '{len: 3'd5, pat: 5'b00011};
         6'd4:  o_lut = '{len: 3'd5, pat: 5'b00001};
         6'd5:  o_lut = '{len: 3'd5, pat: 5'b00000};
         6'd6:  o_lut = '{len: 3'd5, pat: 5'b10000};
         6'd7:  o_lut = '{len: 3'd5, pat: 5'b11000};
         6'd8:  o_lut = '{len: 3'd5, pat: 5'b11100};
         6'd9:  o_lut = '{len: 3'd5, pat: 5'b11110};
         6'd10: o_lut = '{len: 3'd2, pat: 5'b01000};
         6'd11: o_lut = '{len: 3'd4, pat: 5'b10000};
         6'd12: o_lut = '{len: 3'd4, pat: 5'b10100};
         6'd13: o_lut = '{len: 3'd3, pat: 5'b10000};
         6'd14: o_lut = '{len: 3'd1, pat: 5'b00000};
         6'd15: o_lut = '{len: 3'd4, pat: 5'b00100};
         6'd16: o_lut = '{len: 3'd3, pat: 5'b11000};
         6'd17: o_lut = '{len: 3'd4, pat: 5'b00000};
         6'd18: o_lut = '{len: 3'd2, pat: 5'b00000};
         6'd19: o_lut = '{len: 3'd4, pat: 5'b01110};
         6'd20: o_lut = '{len: 3'd3, pat: 5'b10100};
         6'd21: o_lut = '{len: 3'd4, pat: 5'b01000};
         6'd22: o_lut = '{len: 3'd2, pat: 5'b11000};
         6'd23: o_lut = '{len: 3'd2, pat: 5'b10000};
         6'd24: o_lut = '{len: 3'd3, pat: 5'b11100};
         6'd25: o_lut = '{len: 3'd4, pat: 5'b01100};
         6'd26: o_lut = '{len: 3'd4, pat: 5'b11010};
         6'd27: o_lut = '{len: 3'd3, pat: 5'b01000};
         6'd28: o_lut = '{len: 3'd3, pat: 5'b00000};
         6'd29: o_lut = '{len: 3'd1, pat: 5'b10000};
         6'd30: o_lut = '{len: 3'd3, pat: 5'b00100};
         6'd31: o_lut = '{len: 3'd4, pat: 5'b00010};
         6'd32: o_lut = '{len: 3'd3, pat: 5'b01100};
         6'd33: o_lut = '{len: 3'd4, pat: 5'b10010};
         6'd34: o_lut = '{len: 3'd4, pat: 5'b10110};
         6'd35: o_lut = '{len: 3'd4, pat: 5'b11000};
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/morse_encoder.sv
// Morse keying transmitter: accepts one character code per valid/ready
// handshake and plays its mark/space sequence on key, timed in dot units.
module morse_encoder
   import morse_pkg::*;
#(
   parameter int unsigned DOT_CYCLES = 12_000_000
)
(
   input  logic          clk,
   input  logic          res,
   input  logic          data_valid,
   input  logic [5:0]    char_data,
   output logic          ready,
   output logic          key,
   output logic          done,
   output logic          err,
   output morse_state_t  o_dbg_state
);

   // Handshake: a character transfers on any rising edge where
   // data_valid & ready; ready is IDLE decoded from the state register only.
   localparam int unsigned CW = (DOT_CYCLES > 1) ? $clog2(DOT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(DOT_CYCLES - 1);

   morse_state_t  r_state;
   logic [CW-1:0] r_cyc;
   logic [1:0]    r_unit;
   logic [2:0]    r_idx;
   morse_lut_t    r_lut;
   logic          r_key;
   logic          r_done;
   logic          r_err;

   logic          w_rom_valid;
   morse_lut_t    w_rom_lut;
   logic [4:0]    w_pat_shift;
   logic          w_cur_dash;
   logic          w_last_elem;
   logic [1:0]    w_last_unit;
   logic          w_tick;
   logic          w_unit_end;

   morse_rom u_rom (
      .i_code  (char_data),
      .o_valid (w_rom_valid),
      .o_lut   (w_rom_lut)
   );

   assign w_pat_shift = r_lut.pat << r_idx;
   assign w_cur_dash  = w_pat_shift[4];
   assign w_last_elem = (r_idx == 3'(r_lut.len - 3'd1));
   assign w_tick      = (r_cyc == CYC_LAST);
   assign w_unit_end  = w_tick && (r_unit == w_last_unit);

   always_comb begin
      w_last_unit = 2'd0;
      case (r_state)
         ST_MARK:  w_last_unit = w_cur_dash ? last_unit(UNITS_DASH) : last_unit(UNITS_DOT);
         ST_GAP:   w_last_unit = last_unit(UNITS_EGAP);
         ST_CGAP:  w_last_unit = last_unit(UNITS_CGAP);
         ST_SPACE: w_last_unit = last_unit(UNITS_WSPACE);
         default:  w_last_unit = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state <= ST_IDLE;
         r_cyc   <= '0;
         r_unit  <= 2'd0;
         r_idx   <= 3'd0;
         r_lut   <= '0;
         r_key   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         // Timed states share one cycle/unit counter pair, cleared at each unit boundary.
         if (r_state != ST_IDLE && r_state != ST_ERR) begin
            if (w_tick) begin
               r_cyc  <= '0;
               r_unit <= w_unit_end ? 2'd0 : r_unit + 2'd1;
            end else begin
               r_cyc <= r_cyc + CW'(1);
            end
         end
         case (r_state)
            ST_IDLE: begin
               r_cyc  <= '0;
               r_unit <= 2'd0;
               r_idx  <= 3'd0;
               if (data_valid) begin
                  r_lut <= w_rom_lut;
                  if (char_data == CODE_SPACE) begin
                     r_state <= ST_SPACE;
                  end else if (!w_rom_valid) begin
                     r_state <= ST_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= ST_MARK;
                     r_key   <= 1'b1;
                  end
               end
            end
            ST_MARK: begin
               if (w_unit_end) begin
                  r_key   <= 1'b0;
                  r_state <= w_last_elem ? ST_CGAP : ST_GAP;
               end
            end
            ST_GAP: begin
               if (w_unit_end) begin
                  r_key   <= 1'b1;
                  r_idx   <= r_idx + 3'd1;
                  r_state <= ST_MARK;
               end
            end
            ST_CGAP, ST_SPACE: begin
               if (w_unit_end) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_ERR: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_key   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready       = (r_state == ST_IDLE);
   assign key         = r_key;
   assign done        = r_done;
   assign err         = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder at DOT_CYCLES = 4: directed table, back-to-back,
// mid-character reset, and random codes against a string-table Morse model.
module tb_morse_encoder;
   import morse_pkg::*;

   localparam int N = 4;

   logic         clk;
   logic         res;
   logic         data_valid;
   logic [5:0]   char_data;
   logic         ready;
   logic         key;
   logic         done;
   logic         err;
   morse_state_t dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   logic [0:0] exp_q[$];

   string tab[36] = '{"-----", ".----", "..---", "...--", "....-",
                      ".....", "-....", "--...", "---..", "----.",
                      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                      "....", "..", ".---", "-.-", ".-..", "--", "-.",
                      "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                      "...-", ".--", "-..-", "-.--", "--.."};

   typedef struct {
      logic [5:0] code;
      bit         keep;
      int         first_hi;
      int         last_hi;
      int         done_cyc;
   } vec_t;

   morse_encoder #(.DOT_CYCLES(N)) dut (
      .clk         (clk),
      .res         (res),
      .data_valid  (data_valid),
      .char_data   (char_data),
      .ready       (ready),
      .key         (key),
      .done        (done),
      .err         (err),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Expected key level for cycles 1..U*N after acceptance.
   task automatic model(input logic [5:0] code, output bit inv);
      string s;
      int    units;
      exp_q.delete();
      inv = 1'b0;
      if (code > 6'd36) begin
         inv = 1'b1;
      end else if (code == 6'd36) begin
         repeat (4 * N) exp_q.push_back(1'b0);
      end else begin
         s = tab[code];
         for (int j = 0; j < s.len(); j++) begin
            units = (s[j] == 8'h2D) ? 3 : 1;
            repeat (units * N) exp_q.push_back(1'b1);
            if (j < s.len() - 1) repeat (N) exp_q.push_back(1'b0);
         end
         repeat (3 * N) exp_q.push_back(1'b0);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the
   // done (or ready-again) cycle. keep leaves data_valid high for chaining.
   task automatic run_char(input logic [5:0] code, input bit keep, input bit use_tab,
                           input int t_first, input int t_last, input int t_done);
      bit   inv;
      int   len_q, hi_first, hi_last, done_cyc, key_bad, bad_at, busy_bad, rdy_done;
      logic exp_k;
      model(code, inv);
      len_q = exp_q.size();
      data_valid = 1'b1;
      char_data  = code;
      @(posedge clk);
      if (inv) begin
         @(negedge clk);
         check("err_cycle1", {29'd0, err, ready, key}, 32'b100);
         if (keep) char_data = 6'($urandom);
         else data_valid = 1'b0;
         @(negedge clk);
         check("err_cycle2", {28'd0, err, ready, key, done}, 32'b0100);
      end else begin
         hi_first = -1; hi_last = -1; done_cyc = -1;
         key_bad = 0; bad_at = -1; busy_bad = 0; rdy_done = 0;
         for (int k = 1; k <= len_q + 3 && done_cyc < 0; k++) begin
            @(negedge clk);
            exp_k = (k <= len_q) ? exp_q[k-1] : 1'b0;
            if (key !== exp_k) begin
               key_bad++;
               if (bad_at < 0) bad_at = k;
            end
            if (key === 1'b1) begin
               if (hi_first < 0) hi_first = k;
               hi_last = k;
            end
            if (done === 1'b1) begin
               done_cyc = k;
               rdy_done = int'(ready);
            end else if (ready !== 1'b0 || err !== 1'b0) begin
               busy_bad++;
            end
            if (done !== 1'b1) begin
               if (keep) char_data = 6'($urandom);
               else if (k == 1) data_valid = 1'b0;
            end
         end
         if (key_bad != 0) $display("  code %0d: first key deviation in cycle %0d", code, bad_at);
         check("key_wave_bad_cycles", key_bad, 0);
         check("busy_ready_err_bad_cycles", busy_bad, 0);
         check("done_cycle_vs_model", done_cyc, len_q + 1);
         check("ready_in_done_cycle", rdy_done, 1);
         if (use_tab) begin
            check("key_first_high", hi_first, t_first);
            check("key_last_high", hi_last, t_last);
            check("done_cycle_vs_table", done_cyc, t_done);
         end
      end
   endtask

   vec_t vecs[7];
   bit   keep_r;

   initial begin
      // E, A, 0, word space, invalid, then E chained into T (T cycles relative to its own acceptance).
      vecs[0] = '{6'd14, 1'b0, 1, 4, 17};
      vecs[1] = '{6'd10, 1'b0, 1, 20, 33};
      vecs[2] = '{6'd0,  1'b0, 1, 76, 89};
      vecs[3] = '{6'd36, 1'b0, -1, -1, 17};
      vecs[4] = '{6'd40, 1'b0, -1, -1, -1};
      vecs[5] = '{6'd14, 1'b1, 1, 4, 17};
      vecs[6] = '{6'd29, 1'b0, 1, 12, 25};

      res = 1'b0;
      data_valid = 1'b0;
      char_data = 6'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {28'd0, ready, key, done, err}, 32'b1000);
      check("reset_state", dbg_state, ST_IDLE);
      res = 1'b1;
      @(negedge clk);
      check("post_reset_idle", {28'd0, ready, key, done, err}, 32'b1000);

      for (int i = 0; i < 7; i++)
         run_char(vecs[i].code, vecs[i].keep, 1'b1, vecs[i].first_hi, vecs[i].last_hi, vecs[i].done_cyc);
      data_valid = 1'b0;
      @(negedge clk);
      check("done_single_pulse", {30'd0, done, ready}, 32'b01);

      // Reset in the middle of a T dash: key must drop with no clock edge.
      data_valid = 1'b1;
      char_data = 6'd29;
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("key_mid_dash", key, 1'b1);
      #2 res = 1'b0;
      #1 check("reset_async_outputs", {28'd0, ready, key, done, err}, 32'b1000);
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      check("after_reset_no_done", {28'd0, ready, key, done, err}, 32'b1000);
      run_char(6'd14, 1'b0, 1'b1, 1, 4, 17);

      for (int i = 0; i < 40; i++) begin
         keep_r = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_char(6'($urandom_range(0, 63)), keep_r, 1'b0, 0, 0, 0);
      end
      data_valid = 1'b0;
      @(negedge clk);
      check("final_idle", {29'd0, ready, key, err}, 32'b100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
